// File: rtl/subckt_seq_pkg.sv
// Shared types and constants for the subcircuit test sequencer.
package subckt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
  // MISR feedback for x^16+x^12+x^5+1
  localparam logic [15:0] MISR_TAPS     = 16'h1021;
  // Substituted for an all-zero seed so the LFSR cannot lock up
  localparam logic [7:0]  SEED_ZERO_SUB = 8'h01;
  localparam logic [7:0]  LFSR_RESET    = 8'h01;

  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] misr16_step(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_TAPS : 16'h0000) ^ {15'h0000, d};
  endfunction

endpackage

// File: rtl/subckt_test_sequencer_lfsr.sv
// 8-bit pattern LFSR: load from seed (zero seed substituted), advance one step on request.
module seq_lfsr8
  import subckt_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       advance_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // Next state: load has priority over advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? SEED_ZERO_SUB : seed_i;
    end else if (advance_i) begin
      lfsr_d = lfsr8_step(lfsr_q);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_RESET;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/subckt_test_sequencer.sv
// Trojan-detection test sequencer: applies LFSR patterns to a subcircuit,
// waits SETTLE cycles, compares its response with the golden model and
// counts mismatches. Optional response MISR enabled by SUBCKT_SEQ_SIGNATURE_EN.
module subckt_test_sequencer
  import subckt_seq_pkg::*;
#(
  parameter int unsigned PAT_W          = 4,
  parameter int unsigned NUM_PATTERNS   = 256,
  parameter int unsigned SETTLE         = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned MISMATCH_LIMIT = 1
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seed,
  output logic [PAT_W-1:0] pat_out,
  input  logic             dut_resp,
  input  logic             gold_resp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             trojan_flag
`ifdef SUBCKT_SEQ_SIGNATURE_EN
  ,
  output logic [15:0]      signature
`endif
);

  seq_state_e       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [15:0]      pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             flag_q, flag_d;
  logic             lfsr_load, lfsr_adv;
  logic [7:0]       lfsr_state;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
  logic [15:0]      sig_q, sig_d;
`endif

  seq_lfsr8 u_lfsr (
    .clk_i    (I1470_clk),
    .rst_i    (I1477_rst),
    .load_i   (lfsr_load),
    .seed_i   (seed),
    .advance_i(lfsr_adv),
    .state_o  (lfsr_state)
  );

  // Next-state and datapath control; abort wins over every busy-state action
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    pat_cnt_d = pat_cnt_q;
    mcnt_d    = mcnt_q;
    pat_d     = pat_q;
    flag_d    = flag_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
    sig_d     = sig_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          lfsr_load = 1'b1;
          pat_cnt_d = '0;
          mcnt_d    = '0;
          flag_d    = 1'b0;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
          sig_d     = '0;
`endif
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          pat_d    = PAT_W'(lfsr_state);
          settle_d = 4'(SETTLE);
          state_d  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
          if (settle_q <= 4'd1) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if ((dut_resp != gold_resp) && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + CNT_W'(1);
          end
`ifdef SUBCKT_SEQ_SIGNATURE_EN
          sig_d = misr16_step(sig_q, dut_resp);
`endif
          if (pat_cnt_q == 16'(NUM_PATTERNS - 1)) begin
            state_d = ST_DONE;
          end else begin
            pat_cnt_d = pat_cnt_q + 16'd1;
            lfsr_adv  = 1'b1;
            state_d   = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        flag_d  = (32'(mcnt_q) >= MISMATCH_LIMIT);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      pat_cnt_q <= '0;
      mcnt_q    <= '0;
      pat_q     <= '0;
      flag_q    <= 1'b0;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
      sig_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      pat_cnt_q <= pat_cnt_d;
      mcnt_q    <= mcnt_d;
      pat_q     <= pat_d;
      flag_q    <= flag_d;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign pat_out      = pat_q;
  assign busy         = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done         = (state_q == ST_DONE);
  assign mismatch_cnt = mcnt_q;
  assign trojan_flag  = flag_q;
`ifdef SUBCKT_SEQ_SIGNATURE_EN
  assign signature    = sig_q;
`endif

endmodule
